// File: rtl/fu_result_buffer_if.sv
// fu_result_buffer_if: FU_PACKET type plus the FU-side/CDB-side bundle of the result buffer
package fu_result_buffer_pkg;
   typedef struct packed {
      logic [4:0]  reg_idx;
      logic [5:0]  p_reg_idx;
      logic [31:0] reg_val;
      logic        valid;
   } FU_PACKET;
endpackage

interface fu_result_buffer_if
   import fu_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             in_valid;
   FU_PACKET         in_packet;
   logic             in_ready;
   logic             flush;
   logic             stall;
   logic             fu_done;
   FU_PACKET         wr_data;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_packet, flush, stall,
      input  in_ready, fu_done, wr_data, count
   );

   modport slave (
      input  in_valid, in_packet, flush, stall,
      output in_ready, fu_done, wr_data, count
   );
endinterface

// File: rtl/fu_result_buffer.sv
// fu_result_buffer: per-FU circular result queue feeding the CDB arbiter
module fu_result_buffer
   import fu_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic              clock,
   input logic              reset,
   fu_result_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   FU_PACKET         mem_q [DEPTH];
   FU_PACKET         head_pkt;
   logic             push, pop;

   assign bus.in_ready = count_q != CNT_W'(DEPTH);
   assign bus.fu_done  = count_q != '0;
   assign bus.count    = count_q;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = bus.fu_done && !bus.stall;

   // Pointer/count next state; flush wins over push and pop.
   always_comb begin
      head_d  = bus.flush ? '0 : (pop ? head_q + PW'(1) : head_q);
      tail_d  = bus.flush ? '0 : (push ? tail_q + PW'(1) : tail_q);
      count_d = bus.flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Control state register, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy decides what is meaningful.
   always_ff @(posedge clock) begin
      if (push && !bus.flush) mem_q[tail_q] <= bus.in_packet;
   end

   // Head packet with valid forced; all zeros when empty since the CDB wired-ORs packets.
   always_comb begin
      head_pkt       = mem_q[head_q];
      head_pkt.valid = 1'b1;
      bus.wr_data    = bus.fu_done ? head_pkt : '0;
   end
endmodule

// File: tb/tb_fu_result_buffer.sv
// tb_fu_result_buffer: directed self-checking bench for fu_result_buffer
module tb_fu_result_buffer;
   import fu_result_buffer_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   fu_result_buffer_if #(.DEPTH(4)) bus ();

   fu_result_buffer #(.DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic FU_PACKET mk(input logic [7:0] v);
      FU_PACKET p;
      p.reg_idx   = v[4:0];
      p.p_reg_idx = v[7:2];
      p.reg_val   = {24'h0, v};
      p.valid     = 1'b0;
      return p;
   endfunction

   function automatic FU_PACKET ex(input logic [7:0] v);
      FU_PACKET p;
      p       = mk(v);
      p.valid = 1'b1;
      return p;
   endfunction

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic push_stalled(input logic [7:0] base, input int n);
      bus.stall = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_packet = mk(base + 8'(i));
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL reset_fu_done got %b want 0", bus.fu_done); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_vec++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
      n_vec++; if (bus.wr_data !== FU_PACKET'('0)) begin n_bad++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
      @(negedge clock);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single;
      FU_PACKET p;
      p = '0;
      p.reg_idx = 5'd3; p.p_reg_idx = 6'd5; p.reg_val = 32'h11;
      bus.stall = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_packet = p;
      tick();
      bus.in_valid = 1'b0;
      p.valid = 1'b1;
      n_vec++; if (bus.fu_done !== 1'b1) begin n_bad++; $display("FAIL single_fu_done got %b want 1", bus.fu_done); end
      n_vec++; if (bus.wr_data !== p) begin n_bad++; $display("FAIL single_wr_data got %h want %h", bus.wr_data, p); end
      n_vec++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", bus.count); end
      tick();
      n_vec++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL single_drained_count got %0d want 0", bus.count); end
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL single_drained_fu_done got %b want 0", bus.fu_done); end
      n_vec++; if (bus.wr_data !== FU_PACKET'('0)) begin n_bad++; $display("FAIL single_drained_wr_data got %h want 0", bus.wr_data); end
   endtask

   task automatic test_fill;
      push_stalled(8'hA1, 4);
      n_vec++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d want 4", bus.count); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_packet = mk(8'hA5);
      tick();
      bus.in_valid = 1'b0;
      n_vec++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_fifth_count got %0d want 4", bus.count); end
      n_vec++; if (bus.wr_data !== ex(8'hA1)) begin n_bad++; $display("FAIL fill_stalled_hold got %h want %h", bus.wr_data, ex(8'hA1)); end
      bus.stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (bus.wr_data !== ex(8'hA1 + 8'(i))) begin n_bad++; $display("FAIL fill_drain%0d got %h want %h", i, bus.wr_data, ex(8'hA1 + 8'(i))); end
         tick();
      end
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL fill_empty_fu_done got %b want 0", bus.fu_done); end
   endtask

   task automatic test_full_push_pop;
      push_stalled(8'hC1, 4);
      bus.stall = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_packet = mk(8'hB0);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fullpp_in_ready got %b want 0", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_vec++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL fullpp_count got %0d want 3", bus.count); end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (bus.wr_data !== ex(8'hC2 + 8'(i))) begin n_bad++; $display("FAIL fullpp_drain%0d got %h want %h", i, bus.wr_data, ex(8'hC2 + 8'(i))); end
         tick();
      end
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL fullpp_empty got %b want 0", bus.fu_done); end
   endtask

   task automatic test_back_to_back;
      push_stalled(8'hD0, 2);
      bus.stall = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = 1'b1;
         bus.in_packet = mk(8'hD2 + 8'(k));
         n_vec++; if (bus.wr_data !== ex(8'hD0 + 8'(k))) begin n_bad++; $display("FAIL b2b_order%0d got %h want %h", k, bus.wr_data, ex(8'hD0 + 8'(k))); end
         tick();
         n_vec++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL b2b_count%0d got %0d want 2", k, bus.count); end
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (bus.wr_data !== ex(8'hDA + 8'(i))) begin n_bad++; $display("FAIL b2b_tail%0d got %h want %h", i, bus.wr_data, ex(8'hDA + 8'(i))); end
         tick();
      end
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", bus.fu_done); end
   endtask

   task automatic test_flush;
      push_stalled(8'hE1, 3);
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_packet = mk(8'hE4);
      bus.stall = 1'b0;
      n_vec++; if (bus.fu_done !== 1'b1) begin n_bad++; $display("FAIL flush_cycle_fu_done got %b want 1", bus.fu_done); end
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      n_vec++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", bus.count); end
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL flush_fu_done got %b want 0", bus.fu_done); end
      n_vec++; if (bus.wr_data !== FU_PACKET'('0)) begin n_bad++; $display("FAIL flush_wr_data got %h want 0", bus.wr_data); end
      tick();
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL flush_dropped_push got %b want 0", bus.fu_done); end
   endtask

   task automatic test_async_reset;
      push_stalled(8'hF1, 2);
      n_vec++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL areset_pre_count got %0d want 2", bus.count); end
      #2 reset = 1'b1;
      #1;
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL areset_fu_done got %b want 0", bus.fu_done); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready got %b want 1", bus.in_ready); end
      n_vec++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL areset_count got %0d want 0", bus.count); end
      n_vec++; if (bus.wr_data !== FU_PACKET'('0)) begin n_bad++; $display("FAIL areset_wr_data got %h want 0", bus.wr_data); end
      @(negedge clock);
      reset = 1'b0;
      bus.stall = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_packet = mk(8'hF3);
      tick();
      bus.in_valid = 1'b0;
      n_vec++; if (bus.wr_data !== ex(8'hF3)) begin n_bad++; $display("FAIL areset_after got %h want %h", bus.wr_data, ex(8'hF3)); end
      n_vec++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL areset_after_count got %0d want 1", bus.count); end
      tick();
      n_vec++; if (bus.fu_done !== 1'b0) begin n_bad++; $display("FAIL areset_after_empty got %b want 0", bus.fu_done); end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_packet = '0;
      bus.flush     = 1'b0;
      bus.stall     = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_full_push_pop();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fu_result_buffer.md
# fu_result_buffer

Per-functional-unit result queue that sits between an FU's writeback stage and the CDB arbiter. It captures completed results from the FU pipeline and presents the oldest one to the CDB as a `fu_done` request with its `FU_PACKET`. It holds that request while the CDB's `stall_sig` bit for this FU is asserted and pops it on grant. Backpressure reaches the FU through `in_ready`, and a flush input discards all pending results on a branch mispredict.

## Interface
- `DEPTH`, default 4: number of buffered results; power of two, at least 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  FU has a completed result this cycle.
- `in_packet`  in  `FU_PACKET`  result payload: reg_idx, p_reg_idx, reg_val, valid.
- `in_ready`  out  1  buffer can accept a result this cycle.
- `flush`  in  1  discard every buffered result (mispredict squash).
- `stall`  in  1  this FU's bit of the CDB `stall_sig`; 0 means granted this cycle.
- `fu_done`  out  1  request to the CDB; connects to this FU's `fu_done` bit.
- `wr_data`  out  `FU_PACKET`  head result; connects to this FU's `wr_data` slot.
- `count`  out  `CNT_W`  current occupancy, 0..`DEPTH`.

## Operation
- Circular buffer with `DEPTH` entries, a head pointer, a tail pointer and an occupancy counter. The pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- Push = `in_valid && in_ready`. The entry is written at tail, then tail and count each increment.
- Pop = `fu_done && !stall`. Head and count each increment or decrement as appropriate.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.
- `in_ready = (count != DEPTH)`. It depends on registered state only.
  - There is no pop-through when full, so no combinational path runs from `stall` to `in_ready`.
- `fu_done = (count != 0)`, derived from registered state only.
- `wr_data`:
  - When `count != 0`: the head entry, with its `valid` field forced to 1.
  - When `count == 0`: all zeros. This is mandatory, because the CDB wired-ORs packets and derives validity from a nonzero packet.
- `in_packet.valid` is ignored on push; a pushed entry is always treated as valid.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - At the next edge: head = tail = 0 and count = 0. A push or pop offered in the flush cycle is dropped.
  - `fu_done` deasserts the cycle after `flush`. During the flush cycle itself the request stays visible and may be granted; the CDB-side squash logic handles that broadcast.
- `stall` is ignored when `fu_done` = 0.
- Results leave in strict FIFO order.

## Timing
- Reset values (asserted asynchronously): `fu_done`=0, `wr_data`='0, `in_ready`=1, `count`=0, head=tail=0. Entry storage contents are don't-care.
- Push-to-request latency is 1 cycle: a result pushed at edge t is presented to the CDB (`fu_done`=1) in the cycle following edge t. There is no same-cycle bypass.
- A granted head is removed at the following edge. Back-to-back grants drain one entry per cycle.
- A stalled request holds `wr_data` stable, bit-for-bit, until it is granted or flushed.
- Full: `in_ready`=0. Any `in_valid` that cycle is not accepted, and the FU must hold its result.
- Empty plus push plus `stall`: the entry is stored, and the request appears next cycle.
- Reset asserted mid-operation: all outputs return to their reset values without waiting for a clock edge. The buffer is empty and ready on the first edge after reset deasserts.

## Test plan
- Reset, then push reg_val=0x11, p_reg=5 with `stall`=0 → `fu_done`=1 one cycle later with `wr_data`.reg_val=0x11; after that edge `count`=0, `fu_done`=0 and `wr_data`=0.
- With `DEPTH`=4, push 0xA1..0xA4 under `stall`=1 → `count`=4, `in_ready`=0, and a fifth push is ignored. Release `stall` → 0xA1, 0xA2, 0xA3, 0xA4 are presented on consecutive cycles, then `fu_done`=0.
- Full buffer with simultaneous push and grant → pop occurs, push rejected (`in_ready` was 0), `count`=3 next cycle.
- Count=2, simultaneous push and grant → `count` stays 2. Repeat 10 cycles to wrap the pointers; the output order must equal the input order.
- Count=3, `flush`=1 with `in_valid`=1 and `stall`=0 → next cycle `count`=0, `fu_done`=0, `wr_data`=0, and the pushed value never appears.
- Assert `reset` asynchronously between edges with `count`=2 → `fu_done`=0 and `in_ready`=1 immediately, before the next edge.
